// File: rtl/sram_row_access_ctrl.sv
// sram_row_access_ctrl
//   Clocked access sequencer for the word-cell array. It accepts read/write
//   requests on a valid/ready channel and forces a precharge gap (all
//   wordlines low) before every access. During the access cycle it drives one
//   registered one-hot wordline together with rw and word. Read data is
//   captured from the bitlines and returned on a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write                1 = write, 0 = read
//   req_addr                 row address
//   req_wdata                write data
//   rsp_valid/rsp_ready      read response handshake
//   rsp_rdata                captured read word, held until the next read
//   wordLines, rw, word      registered array-facing drive
//   bitLines                 combined column bitlines from the array
//   busy                     high whenever the sequencer is not idle
module sram_row_access_ctrl #(
  parameter int ADDR_W           = 3,
  parameter int WORDS            = 8,
  parameter int DATA_W           = 8,
  parameter int PRECHARGE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [WORDS-1:0]  wordLines,
  output logic              rw,
  output logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] bitLines,
  output logic              busy
);

  localparam int CNT_W = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PRECHARGE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRECHARGE, ACCESS, RESP} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              writeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              fire;
  logic              writeSel;
  logic [DATA_W-1:0] wdataSel;
  logic [WORDS-1:0]  wordLinesNext;
  logic              rwNext;
  logic [DATA_W-1:0] wordNext;

  assign req_ready = (state == IDLE) && !rst;
  assign fire      = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (fire) begin
          stateNext = PRECHARGE;
          cntNext   = CNT_INIT;
        end
      end
      PRECHARGE: begin
        if (cnt == '0) stateNext = ACCESS;
        else           cntNext   = cnt - CNT_W'(1);
      end
      ACCESS:  stateNext = writeQ ? IDLE : RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Array drive is registered, so it is computed from the state being
  // entered. On the handshake cycle the request fields are not latched yet,
  // so the precharge word comes straight from the request.
  assign writeSel = fire ? req_write : writeQ;
  assign wdataSel = fire ? req_wdata : wdataQ;

  // Output logic
  always_comb begin
    wordLinesNext = '0;
    rwNext        = 1'b0;
    wordNext      = '0;
    case (stateNext)
      PRECHARGE: wordNext = writeSel ? wdataSel : '0;
      ACCESS: begin
        // Out-of-range addresses match no row and leave every wordline low.
        for (int unsigned i = 0; i < WORDS; i++)
          wordLinesNext[i] = (ADDR_W'(i) == addrQ);
        if (writeQ) begin
          rwNext   = 1'b1;
          wordNext = wdataQ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wordLines <= '0;
      rw        <= 1'b0;
      word      <= '0;
      rsp_rdata <= '0;
      writeQ    <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
    end else begin
      wordLines <= wordLinesNext;
      rw        <= rwNext;
      word      <= wordNext;
      if (fire) begin
        writeQ <= req_write;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
      end
      if (state == ACCESS && !writeQ)
        rsp_rdata <= bitLines;
    end
  end

endmodule

// File: tb/tb_sram_row_access_ctrl.sv
module tb_sram_row_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqWrite;
  logic [2:0] reqAddr;
  logic [7:0] reqWdata;
  logic       rspReady;

  // Instance A: default geometry, one precharge cycle, backed by an array model
  logic       reqValidA, reqReadyA, rspValidA, rwA, busyA;
  logic [7:0] rdataA, wlA, wordA, bitLinesA;
  logic [7:0] memA [8];

  // Instance B: three precharge cycles
  logic       reqValidB, reqReadyB, rspValidB, rwB, busyB;
  logic [7:0] rdataB, wlB, wordB, bitLinesB;

  // Instance C: six rows behind a 3-bit address
  logic       reqValidC, reqReadyC, rspValidC, rwC, busyC;
  logic [7:0] rdataC, wordC, bitLinesC;
  logic [5:0] wlC;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  sram_row_access_ctrl #(.ADDR_W(3), .WORDS(8), .DATA_W(8), .PRECHARGE_CYCLES(1)) dutA (
    .clk(clk), .rst(rst), .req_valid(reqValidA), .req_ready(reqReadyA),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidA), .rsp_ready(rspReady), .rsp_rdata(rdataA),
    .wordLines(wlA), .rw(rwA), .word(wordA), .bitLines(bitLinesA), .busy(busyA)
  );

  sram_row_access_ctrl #(.ADDR_W(3), .WORDS(8), .DATA_W(8), .PRECHARGE_CYCLES(3)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValidB), .req_ready(reqReadyB),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidB), .rsp_ready(rspReady), .rsp_rdata(rdataB),
    .wordLines(wlB), .rw(rwB), .word(wordB), .bitLines(bitLinesB), .busy(busyB)
  );

  sram_row_access_ctrl #(.ADDR_W(3), .WORDS(6), .DATA_W(8), .PRECHARGE_CYCLES(1)) dutC (
    .clk(clk), .rst(rst), .req_valid(reqValidC), .req_ready(reqReadyC),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValidC), .rsp_ready(rspReady), .rsp_rdata(rdataC),
    .wordLines(wlC), .rw(rwC), .word(wordC), .bitLines(bitLinesC), .busy(busyC)
  );

  // Row i of array A starts out holding 0x11*i. A write commits at the edge
  // that closes the access cycle, unless that edge is a reset edge.
  initial for (int i = 0; i < 8; i++) memA[i] = 8'(i * 17);

  always @(posedge clk)
    if (!rst && rwA)
      for (int i = 0; i < 8; i++)
        if (wlA[i]) memA[i] <= wordA;

  always_comb begin
    bitLinesA = '0;
    for (int i = 0; i < 8; i++)
      if (wlA[i]) bitLinesA = bitLinesA | memA[i];
  end

  // B and C return a fixed pattern whenever any wordline is up, else 0.
  assign bitLinesB = (|wlB) ? 8'hA5 : 8'h00;
  assign bitLinesC = (|wlC) ? 8'h3C : 8'h00;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    reqValidA = 0; reqValidB = 0; reqValidC = 0;
    reqWrite = 0; reqAddr = '0; reqWdata = '0; rspReady = 0;
    tick(); tick();

    // Reset state
    checkVal("rst_wl", 32'(wlA), 32'h00);
    checkVal("rst_rw", 32'(rwA), 32'h0);
    checkVal("rst_word", 32'(wordA), 32'h00);
    checkVal("rst_rspValid", 32'(rspValidA), 32'h0);
    checkVal("rst_rdata", 32'(rdataA), 32'h00);
    checkVal("rst_busy", 32'(busyA), 32'h0);
    checkVal("rst_reqReady", 32'(reqReadyA), 32'h0);
    rst = 1'b0;
    #1;
    checkVal("idle_reqReady", 32'(reqReadyA), 32'h1);
    checkVal("idle_reqReadyB", 32'(reqReadyB), 32'h1);

    // Write addr 2 = 0x55
    reqWrite = 1; reqAddr = 3'd2; reqWdata = 8'h55; reqValidA = 1;
    tick(); reqValidA = 0;
    checkVal("wr2_c1_wl", 32'(wlA), 32'h00);
    checkVal("wr2_c1_busy", 32'(busyA), 32'h1);
    checkVal("wr2_c1_word", 32'(wordA), 32'h55);
    tick();
    checkVal("wr2_c2_wl", 32'(wlA), 32'h04);
    checkVal("wr2_c2_rw", 32'(rwA), 32'h1);
    checkVal("wr2_c2_word", 32'(wordA), 32'h55);
    tick();
    checkVal("wr2_c3_reqReady", 32'(reqReadyA), 32'h1);
    checkVal("wr2_c3_rw", 32'(rwA), 32'h0);
    checkVal("wr2_c3_wl", 32'(wlA), 32'h00);

    // Read addr 2, consumer ready
    reqWrite = 0; reqAddr = 3'd2; rspReady = 1; reqValidA = 1;
    tick(); reqValidA = 0;
    checkVal("rd2_c1_word", 32'(wordA), 32'h00);
    tick();
    checkVal("rd2_c2_wl", 32'(wlA), 32'h04);
    checkVal("rd2_c2_rw", 32'(rwA), 32'h0);
    tick();
    checkVal("rd2_c3_rspValid", 32'(rspValidA), 32'h1);
    checkVal("rd2_c3_rdata", 32'(rdataA), 32'h55);
    checkVal("rd2_c3_reqReady", 32'(reqReadyA), 32'h0);
    tick();
    checkVal("rd2_c4_rspValid", 32'(rspValidA), 32'h0);
    checkVal("rd2_c4_reqReady", 32'(reqReadyA), 32'h1);

    // Write addr 5 = 0x38, then read it back under backpressure
    reqWrite = 1; reqAddr = 3'd5; reqWdata = 8'h38; reqValidA = 1;
    tick(); reqValidA = 0;
    tick(); tick();
    reqWrite = 0; reqAddr = 3'd5; rspReady = 0; reqValidA = 1;
    tick(); reqValidA = 0;
    tick(); tick();
    reqValidA = 1;  // offered during RESP; must not be taken
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("bp_rspValid_%0d", k), 32'(rspValidA), 32'h1);
      checkVal($sformatf("bp_rdata_%0d", k), 32'(rdataA), 32'h38);
      checkVal($sformatf("bp_reqReady_%0d", k), 32'(reqReadyA), 32'h0);
      tick();
    end
    reqValidA = 0;
    checkVal("bp_stillValid", 32'(rspValidA), 32'h1);
    rspReady = 1;
    tick();
    checkVal("bp_done_rspValid", 32'(rspValidA), 32'h0);
    checkVal("bp_done_reqReady", 32'(reqReadyA), 32'h1);
    checkVal("bp_done_rdataHeld", 32'(rdataA), 32'h38);
    checkVal("bp_done_busy", 32'(busyA), 32'h0);

    // Reset during the access cycle of a write to addr 7
    reqWrite = 1; reqAddr = 3'd7; reqWdata = 8'hEE; reqValidA = 1;
    tick(); reqValidA = 0;
    tick();
    checkVal("rstwr_c2_wl", 32'(wlA), 32'h80);
    checkVal("rstwr_c2_rw", 32'(rwA), 32'h1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    checkVal("rstwr_wl", 32'(wlA), 32'h00);
    checkVal("rstwr_rw", 32'(rwA), 32'h0);
    checkVal("rstwr_reqReady", 32'(reqReadyA), 32'h1);
    checkVal("rstwr_rspValid", 32'(rspValidA), 32'h0);
    checkVal("rstwr_rdataCleared", 32'(rdataA), 32'h00);
    tick();
    checkVal("rstwr_rspValid2", 32'(rspValidA), 32'h0);
    reqWrite = 0; reqAddr = 3'd7; reqValidA = 1;
    tick(); reqValidA = 0;
    tick(); tick();
    checkVal("rd7_rspValid", 32'(rspValidA), 32'h1);
    checkVal("rd7_rdata", 32'(rdataA), 32'h77);
    tick();

    // Three precharge cycles, read addr 0
    reqWrite = 0; reqAddr = 3'd0; rspReady = 1; reqValidB = 1;
    tick(); reqValidB = 0;
    for (int c = 1; c <= 3; c++) begin
      checkVal($sformatf("p3_c%0d_wl", c), 32'(wlB), 32'h00);
      checkVal($sformatf("p3_c%0d_rspValid", c), 32'(rspValidB), 32'h0);
      tick();
    end
    checkVal("p3_c4_wl", 32'(wlB), 32'h01);
    checkVal("p3_c4_rw", 32'(rwB), 32'h0);
    tick();
    checkVal("p3_c5_rspValid", 32'(rspValidB), 32'h1);
    checkVal("p3_c5_rdata", 32'(rdataB), 32'hA5);
    checkVal("p3_c5_wl", 32'(wlB), 32'h00);
    tick();
    checkVal("p3_c6_rspValid", 32'(rspValidB), 32'h0);
    checkVal("p3_c6_reqReady", 32'(reqReadyB), 32'h1);

    // Six-row instance: in-range read of addr 1, then out-of-range addr 6
    reqAddr = 3'd1; reqValidC = 1;
    tick(); reqValidC = 0;
    tick();
    checkVal("w6_rd1_wl", 32'(wlC), 32'h02);
    tick();
    checkVal("w6_rd1_rdata", 32'(rdataC), 32'h3C);
    tick();
    reqAddr = 3'd6; reqValidC = 1;
    tick(); reqValidC = 0;
    checkVal("w6_rd6_c1_wl", 32'(wlC), 32'h00);
    tick();
    checkVal("w6_rd6_c2_wl", 32'(wlC), 32'h00);
    checkVal("w6_rd6_c2_busy", 32'(busyC), 32'h1);
    tick();
    checkVal("w6_rd6_c3_wl", 32'(wlC), 32'h00);
    checkVal("w6_rd6_rspValid", 32'(rspValidC), 32'h1);
    checkVal("w6_rd6_rdata", 32'(rdataC), 32'h00);
    tick();
    checkVal("w6_rd6_done", 32'(rspValidC), 32'h0);

    // Out-of-range write on the six-row instance still sequences, rw pulses with no row
    reqWrite = 1; reqAddr = 3'd7; reqWdata = 8'h99; reqValidC = 1;
    tick(); reqValidC = 0;
    tick();
    checkVal("w6_wr7_wl", 32'(wlC), 32'h00);
    checkVal("w6_wr7_rw", 32'(rwC), 32'h1);
    tick();
    checkVal("w6_wr7_reqReady", 32'(reqReadyC), 32'h1);
    checkVal("w6_wr7_rwLow", 32'(rwC), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/sram_row_access_ctrl.md
Name: sram_row_access_ctrl

Overview:
Clocked access sequencer for the word-cell array. It accepts read/write requests on a valid/ready interface and decodes the address into one-hot wordlines. It drives the shared rw and word buses into the array and captures the column bitlines on reads. It returns read data on a valid/ready response channel and enforces a precharge gap (all wordlines low) before every access.

Parameters:
ADDR_W, 3, request address width
WORDS, 8, number of word rows driven (WORDS <= 2**ADDR_W)
DATA_W, 8, word width / bitline count
PRECHARGE_CYCLES, 1, idle cycles with all wordlines low before each access (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  row address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  DATA_W  captured read word
wordLines  output  WORDS  one-hot row select into array
rw  output  1  array read/write strobe (1 = write)
word  output  DATA_W  write data bus into array
bitLines  input  DATA_W  combined column bitline outputs from array
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (clk edge with rst=1) forces the following, regardless of the current state:
  - state=IDLE, wordLines=0, rw=0, word=0, rsp_valid=0, rsp_rdata=0, busy=0, internal counter=0.
  - A mid-operation reset abandons the request; no response is produced.
- All array-facing outputs (wordLines, rw, word) are registered, never combinational from request inputs.
- req_ready = (state==IDLE) && !rst. Handshake fires on a cycle where req_valid && req_ready; addr/write/wdata are latched that cycle.
- FSM states:
  - IDLE: wordLines=0, rw=0. On handshake -> PRECHARGE, counter=PRECHARGE_CYCLES-1.
  - PRECHARGE: wordLines=0, rw=0, word=latched wdata (write) or 0 (read). Counter decrements each cycle. At 0 -> ACCESS.
  - ACCESS (exactly 1 cycle): wordLines[addr]=1, all other bits 0.
    - Write: rw=1, word=wdata; next -> IDLE.
    - Read: rw=0, word=0. bitLines sampled into rsp_rdata at the closing edge; next -> RESP.
  - RESP: rsp_valid=1, rsp_rdata stable. On rsp_valid && rsp_ready -> IDLE with rsp_valid=0 on the next cycle. Holds indefinitely under backpressure.
- Latency, handshake at edge 0, P=PRECHARGE_CYCLES:
  - PRECHARGE occupies cycles 1..P.
  - ACCESS is cycle P+1.
  - Read: rsp_valid rises at cycle P+2.
  - Write: req_ready returns at cycle P+2.
  - Back-to-back throughput: one write per P+2 cycles; one read per P+3 cycles with rsp_ready tied high.
- Out-of-range address (addr >= WORDS):
  - No wordline asserted during ACCESS; the FSM still sequences normally.
  - A write has no effect.
  - A read returns the bitLines value sampled with no wordline active (0 with bitline chain seeded low).
- wordLines is never multi-hot. rw=1 only while exactly one wordline is high (or in the out-of-range write cycle).
- No new request is accepted in RESP even if rsp_ready is high the same cycle; acceptance resumes in IDLE.
- rsp_rdata holds its last value after the response completes, until the next read capture or reset.

Test Plan:
- Reset then write addr=2 data=0x55 (P=1) -> cycle 1 wordLines=0; cycle 2 wordLines=8'b00000100, rw=1, word=0x55; cycle 3 req_ready=1, rw=0.
- Read addr=2 after that write, rsp_ready=1 -> cycle 2 wordLines=8'b00000100, rw=0; cycle 3 rsp_valid=1, rsp_rdata=0x55; cycle 4 rsp_valid=0, req_ready=1.
- Write addr=5 data=0x38, then read addr=5 with rsp_ready low for 4 cycles -> rsp_valid held 4+ cycles with rdata=0x38 stable, req_ready=0 throughout, completes when rsp_ready rises.
- PRECHARGE_CYCLES=3, read addr=0 -> wordLines all-zero for cycles 1-3, 8'b00000001 in cycle 4, rsp_valid in cycle 5.
- Assert rst during ACCESS of a write to addr=7 -> next cycle wordLines=0, rw=0, req_ready=1, no rsp_valid; subsequent read of addr=7 returns the pre-existing value.
- WORDS=6, ADDR_W=3, read addr=6 -> wordLines stays 0 in all cycles, rsp_valid at cycle P+2 with rsp_rdata=0x00.
